// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for a simple bus-based CPU. Steps through
//   IDLE -> T0..T7 -> T0 (or HALT), decoding control strobes from the state
//   register plus the opcode captured on the edge leaving T2.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   stop               request to halt at the next instruction boundary
//   IR[31:0]           instruction register; opcode = IR[31:27]
//   PCout/PCin/IncPc   program counter bus drive, load, increment
//   MARin, MDRin       MAR / MDR load
//   MDRout             MDR bus drive
//   read, write        memory strobes
//   mdr_read[1:0]      MDR source: 01 = memory, 00 = bus
//   IRin, Yin          IR / Y load
//   Zlowin, Zlowout    Z-low load / bus drive
//   Gra, Grb, Grc      register-field selects
//   Rin, Rout, BAout   selected-register load / drive / base-address drive
//   Cout               sign-extended constant bus drive
//   control[3:0]       ALU op: 2 = add, 3 = sub, 0 = idle
//   run                high while sequencing (not IDLE, not HALT)
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPc,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [3:0]  control,
  output logic        run
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_IDLE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [4:0] opcode;
  logic       stop_flag;

  // Only the opcode field is decoded here; operand fields go to the datapath.
  logic       ir_fields_unused;
  assign ir_fields_unused = ^IR[26:0];

  // Instruction class decode; anything unrecognised falls into is_nop.
  logic is_ld, is_ldi, is_st, is_add, is_sub, is_addi, is_halt, is_nop;
  logic [3:0] final_state;

  always_comb begin
    is_ld   = 1'b0;
    is_ldi  = 1'b0;
    is_st   = 1'b0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    is_addi = 1'b0;
    is_halt = 1'b0;
    is_nop  = 1'b0;
    case (opcode)
      OP_LD:   is_ld   = 1'b1;
      OP_LDI:  is_ldi  = 1'b1;
      OP_ST:   is_st   = 1'b1;
      OP_ADD:  is_add  = 1'b1;
      OP_SUB:  is_sub  = 1'b1;
      OP_ADDI: is_addi = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_nop  = 1'b1;
    endcase

    if (is_ld || is_st)
      final_state = S_T7;
    else if (is_nop || is_halt)
      final_state = S_T3;
    else
      final_state = S_T5;
  end

  // Next-state logic. The live stop input is OR'd with the sticky flag so a
  // request arriving in the final state still takes effect at that boundary.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state == S_T3 && is_halt)
          state_nxt = S_HALT;
        else if (state == final_state)
          state_nxt = (stop_flag || stop) ? S_HALT : S_T0;
        else
          state_nxt = state + 4'd1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      stop_flag <= 1'b0;
      opcode    <= OP_NOP;
    end else begin
      state <= state_nxt;
      if (stop)
        stop_flag <= 1'b1;
      if (state == S_T2)
        opcode <= IR[31:27];
    end
  end

  // Moore output decode.
  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPc    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    mdr_read = 2'b00;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Cout     = 1'b0;
    control  = ALU_IDLE;
    run      = (state != S_IDLE) && (state != S_HALT);

    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPc  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        read     = 1'b1;
        mdr_read = 2'b01;
        MDRin    = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_ld || is_ldi || is_st) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_add || is_sub || is_addi) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Zlowin = 1'b1;
        if (is_add || is_sub) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          control = is_sub ? ALU_SUB : ALU_ADD;
        end else begin
          Cout    = 1'b1;
          control = ALU_ADD;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) begin
          Gra      = 1'b1;
          Rout     = 1'b1;
          mdr_read = 2'b00;
        end else begin
          read     = 1'b1;
          mdr_read = 2'b01;
        end
      end
      S_T7: begin
        if (is_st) begin
          write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer. Each row gives the inputs
// held during one clock period and the full output word expected after the
// following rising edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic [31:0] IR = '0;
  logic        PCout, PCin, IncPc, MARin, MDRin, MDRout, read, write;
  logic [1:0]  mdr_read;
  logic        IRin, Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [3:0]  control;
  logic        run;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .stop(stop), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .read(read), .write(write),
    .mdr_read(mdr_read), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .control(control), .run(run)
  );

  logic [25:0] got;
  assign got = {run, PCout, PCin, IncPc, MARin, MDRin, MDRout, read, write,
                mdr_read, IRin, Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin,
                Rout, BAout, Cout, control};

  localparam logic [25:0] B_RUN     = 26'd1 << 25;
  localparam logic [25:0] B_PCOUT   = 26'd1 << 24;
  localparam logic [25:0] B_PCIN    = 26'd1 << 23;
  localparam logic [25:0] B_INCPC   = 26'd1 << 22;
  localparam logic [25:0] B_MARIN   = 26'd1 << 21;
  localparam logic [25:0] B_MDRIN   = 26'd1 << 20;
  localparam logic [25:0] B_MDROUT  = 26'd1 << 19;
  localparam logic [25:0] B_READ    = 26'd1 << 18;
  localparam logic [25:0] B_WRITE   = 26'd1 << 17;
  localparam logic [25:0] B_MDRMEM  = 26'd1 << 15;
  localparam logic [25:0] B_IRIN    = 26'd1 << 14;
  localparam logic [25:0] B_YIN     = 26'd1 << 13;
  localparam logic [25:0] B_ZLOWIN  = 26'd1 << 12;
  localparam logic [25:0] B_ZLOWOUT = 26'd1 << 11;
  localparam logic [25:0] B_GRA     = 26'd1 << 10;
  localparam logic [25:0] B_GRB     = 26'd1 << 9;
  localparam logic [25:0] B_GRC     = 26'd1 << 8;
  localparam logic [25:0] B_RIN     = 26'd1 << 7;
  localparam logic [25:0] B_ROUT    = 26'd1 << 6;
  localparam logic [25:0] B_BAOUT   = 26'd1 << 5;
  localparam logic [25:0] B_COUT    = 26'd1 << 4;
  localparam logic [25:0] C_ADD     = 26'd2;
  localparam logic [25:0] C_SUB     = 26'd3;

  localparam logic [25:0] E_OFF  = '0;
  localparam logic [25:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [25:0] E_T1   = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRMEM | B_MDRIN;
  localparam logic [25:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [25:0] E_BA3  = B_RUN | B_GRB | B_BAOUT | B_YIN;
  localparam logic [25:0] E_R3   = B_RUN | B_GRB | B_ROUT | B_YIN;
  localparam logic [25:0] E_C4   = B_RUN | B_COUT | C_ADD | B_ZLOWIN;
  localparam logic [25:0] E_ADD4 = B_RUN | B_GRC | B_ROUT | C_ADD | B_ZLOWIN;
  localparam logic [25:0] E_SUB4 = B_RUN | B_GRC | B_ROUT | C_SUB | B_ZLOWIN;
  localparam logic [25:0] E_WB5  = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;
  localparam logic [25:0] E_MA5  = B_RUN | B_ZLOWOUT | B_MARIN;
  localparam logic [25:0] E_LD6  = B_RUN | B_READ | B_MDRMEM | B_MDRIN;
  localparam logic [25:0] E_LD7  = B_RUN | B_MDROUT | B_GRA | B_RIN;
  localparam logic [25:0] E_ST6  = B_RUN | B_GRA | B_ROUT | B_MDRIN;
  localparam logic [25:0] E_ST7  = B_RUN | B_WRITE;
  localparam logic [25:0] E_NOP3 = B_RUN;

  localparam logic [31:0] IR_LDI  = {5'b00001, 4'd0, 4'd1, 19'd35};
  localparam logic [31:0] IR_ADD  = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] IR_SUB  = {5'b00100, 4'd4, 4'd3, 4'd1, 15'd0};
  localparam logic [31:0] IR_ADDI = {5'b01100, 4'd5, 4'd2, 19'd7};
  localparam logic [31:0] IR_ST   = {5'b00010, 4'd1, 4'd2, 19'd10};
  localparam logic [31:0] IR_LD   = {5'b00000, 4'd6, 4'd2, 19'd20};
  localparam logic [31:0] IR_UND  = {5'b11111, 27'd0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};
  localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

  typedef struct {
    logic        rst;
    logic        stp;
    logic [31:0] ir;
    logic [25:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic add_vec(input logic r, input logic s, input logic [31:0] ir,
                         input logic [25:0] e, input string tag);
    vec_t v;
    v.rst = r;
    v.stp = s;
    v.ir  = ir;
    v.exp = e;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic q(input logic [31:0] ir, input logic [25:0] e, input string tag);
    add_vec(1'b0, 1'b0, ir, e, tag);
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] ir,
                      input logic [25:0] e, input string tag);
    int unsigned drivers;
    @(negedge clk);
    reset = r;
    stop  = s;
    IR    = ir;
    @(posedge clk);
    #1;
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: outputs %h, required %h", tag, got, e);
    end
    drivers = 32'(PCout) + 32'(MDRout) + 32'(Zlowout) + 32'(Rout) + 32'(BAout) + 32'(Cout);
    n_tests++;
    if (drivers > 1 || (read && write)) begin
      n_fail++;
      $display("FAIL %s bus_excl: drivers %0d rd %b wr %b, required drivers<=1 and not both strobes",
               tag, drivers, read, write);
    end
  endtask

  task automatic fetch(input logic [31:0] ir, input string name);
    q(ir, E_T0, {name, " T0"});
    q(ir, E_T1, {name, " T1"});
    q(ir, E_T2, {name, " T2"});
  endtask

  initial begin
    // Main instruction stream from a single reset.
    add_vec(1'b1, 1'b0, IR_LDI, E_OFF, "reset idle");
    fetch(IR_LDI, "ldi");
    q(IR_LDI, E_BA3, "ldi T3");
    q(IR_ADD, E_C4,  "ldi T4");   // IR already changed: latched opcode must hold
    q(IR_ADD, E_WB5, "ldi T5");
    fetch(IR_ADD, "add");
    q(IR_ADD, E_R3,   "add T3");
    q(IR_ADD, E_ADD4, "add T4");
    q(IR_ADD, E_WB5,  "add T5");
    fetch(IR_SUB, "sub");
    q(IR_SUB, E_R3,   "sub T3");
    q(IR_SUB, E_SUB4, "sub T4");
    q(IR_SUB, E_WB5,  "sub T5");
    fetch(IR_ADDI, "addi");
    q(IR_ADDI, E_R3,  "addi T3");
    q(IR_ADDI, E_C4,  "addi T4");
    q(IR_ADDI, E_WB5, "addi T5");
    fetch(IR_ST, "st");
    q(IR_ST, E_BA3, "st T3");
    q(IR_ST, E_C4,  "st T4");
    q(IR_ST, E_MA5, "st T5");
    q(IR_ST, E_ST6, "st T6");
    q(IR_ST, E_ST7, "st T7");
    fetch(IR_LD, "ld");
    q(IR_LD, E_BA3, "ld T3");
    q(IR_LD, E_C4,  "ld T4");
    q(IR_LD, E_MA5, "ld T5");
    q(IR_LD, E_LD6, "ld T6");
    q(IR_LD, E_LD7, "ld T7");
    fetch(IR_UND, "undef");
    q(IR_UND, E_NOP3, "undef T3");
    fetch(IR_NOP, "nop");
    q(IR_NOP, E_NOP3, "nop T3");
    q(IR_NOP, E_T0,   "after nop T0");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].stp, vecs[i].ir, vecs[i].exp, vecs[i].tag);

    // stop pulsed during T3 of ld: ld completes, then HALT until reset.
    step(1'b1, 1'b0, IR_LD, E_OFF, "stopld reset");
    step(1'b0, 1'b0, IR_LD, E_T0,  "stopld T0");
    step(1'b0, 1'b0, IR_LD, E_T1,  "stopld T1");
    step(1'b0, 1'b0, IR_LD, E_T2,  "stopld T2");
    step(1'b0, 1'b0, IR_LD, E_BA3, "stopld T3");
    step(1'b0, 1'b1, IR_LD, E_C4,  "stopld T4");
    step(1'b0, 1'b0, IR_LD, E_MA5, "stopld T5");
    step(1'b0, 1'b0, IR_LD, E_LD6, "stopld T6");
    step(1'b0, 1'b0, IR_LD, E_LD7, "stopld T7");
    for (int unsigned k = 0; k < 20; k++)
      step(1'b0, 1'b0, IR_LD, E_OFF, "stopld halt");
    step(1'b1, 1'b0, IR_ST, E_OFF, "halt reset idle");
    step(1'b0, 1'b0, IR_ST, E_T0,  "halt reset T0");

    // Reset during T6 of st: no write in the following cycle.
    step(1'b0, 1'b0, IR_ST, E_T1,  "strst T1");
    step(1'b0, 1'b0, IR_ST, E_T2,  "strst T2");
    step(1'b0, 1'b0, IR_ST, E_BA3, "strst T3");
    step(1'b0, 1'b0, IR_ST, E_C4,  "strst T4");
    step(1'b0, 1'b0, IR_ST, E_MA5, "strst T5");
    step(1'b0, 1'b0, IR_ST, E_ST6, "strst T6");
    step(1'b1, 1'b0, IR_ST, E_OFF, "strst idle");
    step(1'b0, 1'b0, IR_HALT, E_T0, "strst T0");

    // halt opcode: T3 then HALT, persisting without stop.
    step(1'b0, 1'b0, IR_HALT, E_T1,   "halt T1");
    step(1'b0, 1'b0, IR_HALT, E_T2,   "halt T2");
    step(1'b0, 1'b0, IR_HALT, E_NOP3, "halt T3");
    for (int unsigned k = 0; k < 3; k++)
      step(1'b0, 1'b0, IR_NOP, E_OFF, "halt state");

    // stop arriving in the final state (nop T3) takes effect at that boundary.
    step(1'b1, 1'b0, IR_NOP, E_OFF,  "laststop reset");
    step(1'b0, 1'b0, IR_NOP, E_T0,   "laststop T0");
    step(1'b0, 1'b0, IR_NOP, E_T1,   "laststop T1");
    step(1'b0, 1'b0, IR_NOP, E_T2,   "laststop T2");
    step(1'b0, 1'b0, IR_NOP, E_NOP3, "laststop T3");
    step(1'b0, 1'b1, IR_NOP, E_OFF,  "laststop halt");
    step(1'b0, 1'b0, IR_NOP, E_OFF,  "laststop hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
